// File: rtl/countdown_sequencer.sv
// Round-start countdown: shows "3", "2", "1", "FIGHT" sprites for a set number of
// frames each, then hands control to the game until the round ends. The output
// pixel is the countdown sprite keyed over the game scene.
module countdown_sequencer #(
  parameter int unsigned FRAMES_PER_DIGIT = 60,
  parameter int unsigned FIGHT_FRAMES     = 45,
  parameter logic [11:0] KEY              = 12'hF0F
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic        start,
  input  logic        round_over,
  input  logic        blank,
  input  logic [11:0] cd3_rgb,
  input  logic [11:0] cd2_rgb,
  input  logic [11:0] cd1_rgb,
  input  logic [11:0] fight_rgb,
  input  logic [11:0] game_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [2:0]  phase,
  output logic        controls_enable,
  output logic        fight_start
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StShow3 = 3'd1,
    StShow2 = 3'd2,
    StShow1 = 3'd3,
    StFight = 3'd4,
    StPlay  = 3'd5
  } state_e;

  localparam logic [7:0] DigitLast = 8'(FRAMES_PER_DIGIT - 1);
  localparam logic [7:0] FightLast = 8'(FIGHT_FRAMES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vsync_q;
  logic        frame_tick;
  logic        ctrl_en_q, ctrl_en_d;
  logic        fight_start_q, fight_start_d;
  logic [11:0] rgb_q, rgb_d;
  logic        overlay_valid;
  logic [11:0] overlay_rgb;
  logic [11:0] composite_rgb;

  assign frame_tick = vsync & ~vsync_q;

  // Next state and frame counter; a tick that causes a transition is consumed by it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShow3;
          cnt_d   = '0;
        end
      end
      StShow3, StShow2, StShow1: begin
        if (frame_tick) begin
          if (cnt_q == DigitLast) begin
            // Show3 -> Show2 -> Show1 -> Fight are consecutive encodings.
            state_d = state_e'(state_q + 3'd1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StFight: begin
        if (frame_tick) begin
          if (cnt_q == FightLast) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StPlay: begin
        if (round_over) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are computed from the next state so they register alongside it.
  always_comb begin
    ctrl_en_d     = (state_d == StFight) || (state_d == StPlay);
    fight_start_d = (state_d == StFight) && (state_q != StFight);
  end

  // Overlay selection uses the current state, so a state change affects the next pixel.
  always_comb begin
    overlay_valid = 1'b1;
    overlay_rgb   = '0;
    unique case (state_q)
      StShow3: overlay_rgb = cd3_rgb;
      StShow2: overlay_rgb = cd2_rgb;
      StShow1: overlay_rgb = cd1_rgb;
      StFight: overlay_rgb = fight_rgb;
      default: overlay_valid = 1'b0;
    endcase
    composite_rgb = (overlay_valid && (overlay_rgb != KEY)) ? overlay_rgb : game_rgb;
    rgb_d         = blank ? composite_rgb : 12'h000;
  end

  // State, counter, vsync history and registered outputs with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      vsync_q       <= 1'b0;
      ctrl_en_q     <= 1'b0;
      fight_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vsync_q       <= vsync;
      ctrl_en_q     <= ctrl_en_d;
      fight_start_q <= fight_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign phase           = state_q;
  assign controls_enable = ctrl_en_q;
  assign fight_start     = fight_start_q;
  assign red             = rgb_q[11:8];
  assign green           = rgb_q[7:4];
  assign blue            = rgb_q[3:0];

endmodule
